// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared types for the I2C register-access sequencer.
// Holds the sequencer state enum and its fixed encoding.
// Imported by i2c_reg_ctrl.
package i2c_reg_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 3'd0,
    ADDR_WAIT   = 3'd1,
    GET_PTR     = 3'd2,
    WR_DATA     = 3'd3,
    WR_STROBE   = 3'd4,
    RD_WAIT_REQ = 3'd5,
    RD_FETCH    = 3'd6,
    RD_OFFER    = 3'd7
  } state_t;

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Purpose: sequences I2C slave byte traffic into register bus writes/reads via an auto-incrementing pointer.
// Latency: write byte -> reg_we next cycle (one byte per 2 cycles); reg_re -> read_valid one cycle after reg_rvalid.
// Backpressure: write_ready drops during the strobe cycle; reads are fetched only on read_ready, offered until taken.
// Optional macro I2C_REG_CTRL_RD_TIMEOUT_EN: bounds the reg_rvalid wait by TIMEOUT_CYCLES, returns 0xFF and adds sticky rd_timeout.
module i2c_reg_ctrl
  import i2c_reg_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  read,
  input  logic                  write,
  input  logic                  write_valid,
  input  logic [7:0]            write_data,
  output logic                  write_ready,
  output logic                  read_valid,
  output logic [7:0]            read_data,
  input  logic                  read_ready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  input  logic                  reg_rvalid,
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
  output logic                  rd_timeout,
`endif
  output logic                  busy
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pointer;

`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] to_cnt;
`endif

  assign reg_addr = pointer;
  assign busy     = (state != IDLE);

  // Sequencer: state, pointer and all handshake/strobe outputs are registered here.
  // Strobes default low each cycle; the pointer only moves after a completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pointer     <= '0;
      write_ready <= 1'b0;
      read_valid  <= 1'b0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      read_data   <= 8'h00;
      reg_wdata   <= 8'h00;
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
      rd_timeout  <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      write_ready <= 1'b0;
      read_valid  <= 1'b0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      if (stop) begin
        // Any in-flight access is abandoned; the pointer is kept for the next transaction.
        state <= IDLE;
      end else if (start) begin
        state <= ADDR_WAIT;
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
        rd_timeout <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR_WAIT: begin
            if (write) begin
              state       <= GET_PTR;
              write_ready <= 1'b1;
            end else if (read) begin
              state <= RD_WAIT_REQ;
            end
          end
          GET_PTR: begin
            write_ready <= 1'b1;
            if (write_valid && write_ready) begin
              pointer <= ADDR_WIDTH'(write_data);
              state   <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (write_valid && write_ready) begin
              reg_wdata <= write_data;
              reg_we    <= 1'b1;
              state     <= WR_STROBE;
            end else begin
              write_ready <= 1'b1;
            end
          end
          WR_STROBE: begin
            pointer     <= pointer + ADDR_WIDTH'(1);
            write_ready <= 1'b1;
            state       <= WR_DATA;
          end
          RD_WAIT_REQ: begin
            // Fetch only on demand so the register bus never sees a read-ahead.
            if (read_ready) begin
              reg_re <= 1'b1;
              state  <= RD_FETCH;
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
          RD_FETCH: begin
            if (reg_rvalid) begin
              read_data  <= reg_rdata;
              read_valid <= 1'b1;
              state      <= RD_OFFER;
            end
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
            else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              read_data  <= 8'hFF;
              read_valid <= 1'b1;
              rd_timeout <= 1'b1;
              state      <= RD_OFFER;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
          end
          RD_OFFER: begin
            if (read_valid && read_ready) begin
              pointer <= pointer + ADDR_WIDTH'(1);
              state   <= RD_WAIT_REQ;
            end else begin
              read_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: a cycle-by-cycle vector table plus short hand-written read sequences.
// Inputs are driven on the falling edge; outputs are compared 1 time unit after the rising edge.
// Define I2C_REG_CTRL_RD_TIMEOUT_EN to also exercise the read timeout with TIMEOUT_CYCLES=4.
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, read, write, write_valid, read_ready, reg_rvalid;
  logic [7:0] write_data, reg_rdata;
  logic       write_ready, read_valid, reg_we, reg_re, busy;
  logic [7:0] read_data, reg_wdata, reg_addr;
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
  logic       rd_timeout;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int re_seen;

  always #5 clk = ~clk;

`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
  i2c_reg_ctrl #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
`else
  i2c_reg_ctrl #(.ADDR_WIDTH(8)) dut (
`endif
    .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
    .write_valid(write_valid), .write_data(write_data), .write_ready(write_ready),
    .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
    .rd_timeout(rd_timeout),
`endif
    .busy(busy)
  );

  // ctl = {rst,start,stop,read,write,write_valid}; flags = {write_ready,reg_we,reg_re,read_valid,busy}
  typedef struct {
    logic [5:0] ctl;
    logic [7:0] wd;
    logic       rr;
    logic       rv;
    logic [7:0] rdat;
    logic [4:0] e_flags;
    logic [7:0] e_addr;
    logic [7:0] e_wdat;
    logic [7:0] e_rdat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [5:0] ctl, logic [7:0] wd, logic rr, logic rv, logic [7:0] rdat,
                              logic [4:0] ef, logic [7:0] ea, logic [7:0] ew, logic [7:0] er);
    vec_t v;
    v.ctl = ctl; v.wd = wd; v.rr = rr; v.rv = rv; v.rdat = rdat;
    v.e_flags = ef; v.e_addr = ea; v.e_wdat = ew; v.e_rdat = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [5:0] ctl, input logic [7:0] wd, input logic rr, input logic rv,
                     input logic [7:0] rdat);
    @(negedge clk);
    {rst, start, stop, read, write, write_valid} = ctl;
    write_data = wd; read_ready = rr; reg_rvalid = rv; reg_rdata = rdat;
    @(posedge clk);
    #1;
    if (reg_re) re_seen++;
  endtask

  task automatic idle();
    drv(6'b000000, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    {rst, start, stop, read, write, write_valid, read_ready, reg_rvalid} = '0;
    write_data = 8'h00; reg_rdata = 8'h00;
    re_seen = 0;

    //               ctl        wd     rr    rv    rdat     flags     addr   wdat   rdat
    vt.push_back(mk(6'b100000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00)); // reset
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h00, 8'h00, 8'h00)); // start
    vt.push_back(mk(6'b000010, 8'h00, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h00, 8'h00, 8'h00)); // write addr
    vt.push_back(mk(6'b000001, 8'h10, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h10, 8'h00, 8'h00)); // pointer
    vt.push_back(mk(6'b000001, 8'hAA, 1'b0, 1'b0, 8'h00, 5'b01001, 8'h10, 8'hAA, 8'h00)); // strobe AA
    vt.push_back(mk(6'b000001, 8'hBB, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h11, 8'hAA, 8'h00)); // not taken
    vt.push_back(mk(6'b000001, 8'hBB, 1'b0, 1'b0, 8'h00, 5'b01001, 8'h11, 8'hBB, 8'h00)); // strobe BB
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h12, 8'hBB, 8'h00));
    vt.push_back(mk(6'b001000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h12, 8'hBB, 8'h00)); // stop
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h12, 8'hBB, 8'h00));
    vt.push_back(mk(6'b000010, 8'h00, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h12, 8'hBB, 8'h00));
    vt.push_back(mk(6'b000001, 8'hFF, 1'b0, 1'b0, 8'h00, 5'b10001, 8'hFF, 8'hBB, 8'h00)); // ptr FF
    vt.push_back(mk(6'b000001, 8'h01, 1'b0, 1'b0, 8'h00, 5'b01001, 8'hFF, 8'h01, 8'h00));
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h00, 8'h01, 8'h00)); // wrap
    vt.push_back(mk(6'b000001, 8'h77, 1'b0, 1'b0, 8'h00, 5'b01001, 8'h00, 8'h77, 8'h00));
    vt.push_back(mk(6'b001000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h00, 8'h77, 8'h00)); // stop in strobe
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h00, 8'h77, 8'h00));
    vt.push_back(mk(6'b000001, 8'h55, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h00, 8'h77, 8'h00)); // byte in ADDR_WAIT
    vt.push_back(mk(6'b000010, 8'h00, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h00, 8'h77, 8'h00));
    vt.push_back(mk(6'b000001, 8'h20, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h20, 8'h77, 8'h00)); // ptr 20
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h20, 8'h77, 8'h00)); // rep start
    vt.push_back(mk(6'b000100, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h20, 8'h77, 8'h00)); // read addr
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h20, 8'h77, 8'h00));
    vt.push_back(mk(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00, 5'b00101, 8'h20, 8'h77, 8'h00)); // reg_re
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h20, 8'h77, 8'h00));
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b1, 8'h5A, 5'b00011, 8'h20, 8'h77, 8'h5A)); // offer 5A
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00011, 8'h20, 8'h77, 8'h5A));
    vt.push_back(mk(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00, 5'b00001, 8'h21, 8'h77, 8'h5A)); // taken
    vt.push_back(mk(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00, 5'b00101, 8'h21, 8'h77, 8'h5A));
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b1, 8'hC3, 5'b00011, 8'h21, 8'h77, 8'hC3));
    vt.push_back(mk(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00, 5'b00001, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b001000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b000100, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00, 5'b00101, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b001000, 8'h00, 1'b0, 1'b1, 8'h99, 5'b00000, 8'h22, 8'h77, 8'hC3)); // stop+rvalid
    vt.push_back(mk(6'b000000, 8'h00, 1'b0, 1'b1, 8'h11, 5'b00000, 8'h22, 8'h77, 8'hC3)); // stray rvalid
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b011000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h22, 8'h77, 8'hC3)); // stop beats start
    vt.push_back(mk(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00, 5'b00001, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b000010, 8'h00, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h22, 8'h77, 8'hC3));
    vt.push_back(mk(6'b000001, 8'h33, 1'b0, 1'b0, 8'h00, 5'b10001, 8'h33, 8'h77, 8'hC3));
    vt.push_back(mk(6'b100001, 8'h44, 1'b0, 1'b0, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00)); // rst mid-write

    for (int i = 0; i < vt.size(); i++) begin
      drv(vt[i].ctl, vt[i].wd, vt[i].rr, vt[i].rv, vt[i].rdat);
      chk($sformatf("vec%0d {wrdy,we,re,rvld,busy,addr,wdat,rdat}", i),
          32'({write_ready, reg_we, reg_re, read_valid, busy, reg_addr, reg_wdata, read_data}),
          32'({vt[i].e_flags, vt[i].e_addr, vt[i].e_wdat, vt[i].e_rdat}));
    end

    // Read with a 3-cycle register bus, then confirm no fetch happens without read_ready.
    re_seen = 0;
    drv(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00);
    drv(6'b000010, 8'h00, 1'b0, 1'b0, 8'h00);
    drv(6'b000001, 8'h40, 1'b0, 1'b0, 8'h00);
    drv(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00);
    drv(6'b000100, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(); idle();
    chk("no_fetch_without_ready", 32'(re_seen), 32'd0);
    drv(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("re_at_ptr", 32'({reg_re, reg_addr}), 32'({1'b1, 8'h40}));
    idle(); idle();
    drv(6'b000000, 8'h00, 1'b0, 1'b1, 8'hE7);
    n = 0;
    while (!read_valid && n < 8) begin
      idle();
      n++;
    end
    chk("offer_after_bus", 32'({read_valid, read_data}), 32'({1'b1, 8'hE7}));
    for (int k = 0; k < 4; k++) idle();
    chk("offer_held", 32'({read_valid, read_data, reg_addr}), 32'({1'b1, 8'hE7, 8'h40}));
    chk("single_fetch", 32'(re_seen), 32'd1);
    drv(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("read_incr", 32'({read_valid, reg_addr}), 32'({1'b0, 8'h41}));
    drv(6'b001000, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("stop_idle", 32'({busy, reg_addr}), 32'({1'b0, 8'h41}));

`ifdef I2C_REG_CTRL_RD_TIMEOUT_EN
    // Register bus never answers: 0xFF appears after TIMEOUT_CYCLES cycles in RD_FETCH.
    chk("to_flag_idle", 32'(rd_timeout), 32'd0);
    drv(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00);
    drv(6'b000100, 8'h00, 1'b0, 1'b0, 8'h00);
    drv(6'b000000, 8'h00, 1'b1, 1'b0, 8'h00);
    n = 0;
    while (!read_valid && n < 20) begin
      idle();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd4);
    chk("to_offer", 32'({read_valid, read_data, rd_timeout}), 32'({1'b1, 8'hFF, 1'b1}));
    drv(6'b001000, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("to_sticky_stop", 32'({rd_timeout, reg_addr}), 32'({1'b1, 8'h41}));
    drv(6'b010000, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("to_clr_start", 32'(rd_timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
